// File: rtl/cy_stream_serializer.sv
// rtl/cy_stream_serializer.sv - wide-word to DW-bit beat serializer with registered valid/ready output
module cy_stream_serializer #(
  parameter int DW        = 8,
  parameter int NBEATS    = 4,
  parameter int MSB_FIRST = 1,
  parameter int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DW*NBEATS-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DW-1:0]        o_data,
  output logic                 o_last,
  output logic [BW-1:0]        o_beat
);

  localparam int W = DW * NBEATS;
  localparam logic [BW-1:0] LAST_IDX = BW'(NBEATS - 1);

  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

  state_t          state_q;
  logic [W-1:0]    sh_q;
  logic            valid_q;
  logic [DW-1:0]   data_q;
  logic            last_q;
  logic [BW-1:0]   beat_q;

  logic            accept;
  logic            advance;
  logic [DW-1:0]   load_beat;
  logic [W-1:0]    load_rest;
  logic [DW-1:0]   next_beat;
  logic [W-1:0]    next_rest;
  logic [BW-1:0]   beat_inc;

  // Upstream ready: idle, or the last beat is leaving this edge (zero-bubble reload).
  // Combinational from i_ready by design.
  always_comb begin
    o_ready = !i_reset && ((state_q == S_IDLE) || (valid_q && i_ready && last_q));
  end

  // Beat extraction: the shift register holds the not-yet-sent beats aligned to
  // the end that gets emitted next, so every pick comes from a fixed slice.
  always_comb begin
    accept    = i_valid && o_ready;
    advance   = valid_q && i_ready;
    beat_inc  = beat_q + BW'(1);
    load_beat = (MSB_FIRST != 0) ? i_data[W-1 -: DW] : i_data[DW-1:0];
    load_rest = (MSB_FIRST != 0) ? (i_data << DW) : (i_data >> DW);
    next_beat = (MSB_FIRST != 0) ? sh_q[W-1 -: DW] : sh_q[DW-1:0];
    next_rest = (MSB_FIRST != 0) ? (sh_q << DW) : (sh_q >> DW);
  end

  // Serializer FSM: load on accept, step on each downstream handshake, hold on stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
    end else if (accept) begin
      state_q <= S_SEND;
      valid_q <= 1'b1;
      data_q  <= load_beat;
      sh_q    <= load_rest;
      beat_q  <= '0;
      last_q  <= (NBEATS == 1);
    end else if (advance) begin
      if (last_q) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        data_q  <= next_beat;
        sh_q    <= next_rest;
        beat_q  <= beat_inc;
        last_q  <= (beat_inc == LAST_IDX);
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_beat  = beat_q;

endmodule

// File: tb/tb_cy_stream_serializer.sv
// tb/tb_cy_stream_serializer.sv - directed self-checking bench for cy_stream_serializer
module tb_cy_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // main instance: DW=8, NBEATS=4, MSB_FIRST=1
  logic        m_ivalid, m_oready, m_ovalid, m_iready, m_olast;
  logic [31:0] m_idata;
  logic [7:0]  m_odata;
  logic [1:0]  m_obeat;

  // LSB-first instance
  logic        l_ivalid, l_oready, l_ovalid, l_iready, l_olast;
  logic [31:0] l_idata;
  logic [7:0]  l_odata;
  logic [1:0]  l_obeat;

  // single-beat instance
  logic        n_ivalid, n_oready, n_ovalid, n_iready, n_olast;
  logic [7:0]  n_idata;
  logic [7:0]  n_odata;
  logic [0:0]  n_obeat;

  cy_stream_serializer #(.DW(8), .NBEATS(4), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_reset(rst), .i_valid(m_ivalid), .o_ready(m_oready), .i_data(m_idata),
    .o_valid(m_ovalid), .i_ready(m_iready), .o_data(m_odata), .o_last(m_olast), .o_beat(m_obeat)
  );

  cy_stream_serializer #(.DW(8), .NBEATS(4), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_reset(rst), .i_valid(l_ivalid), .o_ready(l_oready), .i_data(l_idata),
    .o_valid(l_ovalid), .i_ready(l_iready), .o_data(l_odata), .o_last(l_olast), .o_beat(l_obeat)
  );

  cy_stream_serializer #(.DW(8), .NBEATS(1), .MSB_FIRST(1)) u_one (
    .i_clk(clk), .i_reset(rst), .i_valid(n_ivalid), .o_ready(n_oready), .i_data(n_idata),
    .o_valid(n_ovalid), .i_ready(n_iready), .o_data(n_odata), .o_last(n_olast), .o_beat(n_obeat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle on the main instance: drive inputs at the negedge, then check outputs.
  // Data and beat index are only meaningful while o_valid is expected high.
  task automatic tick(input string tag, input logic iv, input logic [31:0] id, input logic ir,
                      input logic ev, input logic [7:0] ed, input logic [1:0] eb,
                      input logic el, input logic er);
    @(negedge clk);
    m_ivalid = iv;
    m_idata  = id;
    m_iready = ir;
    #1;
    check({tag, ".valid"}, 32'(m_ovalid), 32'(ev));
    check({tag, ".last"},  32'(m_olast),  32'(el));
    check({tag, ".ready"}, 32'(m_oready), 32'(er));
    if (ev) begin
      check({tag, ".data"}, 32'(m_odata), 32'(ed));
      check({tag, ".beat"}, 32'(m_obeat), 32'(eb));
    end
  endtask

  initial begin
    rst = 1'b1;
    m_ivalid = 0; m_idata = 0; m_iready = 0;
    l_ivalid = 0; l_idata = 0; l_iready = 0;
    n_ivalid = 0; n_idata = 0; n_iready = 0;

    // reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst.valid", 32'(m_ovalid), 0);
    check("rst.data",  32'(m_odata),  0);
    check("rst.last",  32'(m_olast),  0);
    check("rst.beat",  32'(m_obeat),  0);
    check("rst.ready", 32'(m_oready), 0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(m_oready), 1);

    // 1: single word
    tick("t1.acc", 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1);
    tick("t1.b0",  0, 32'h0,        1, 1, 8'hA1, 0, 0, 0);
    tick("t1.b1",  0, 32'h0,        1, 1, 8'hB2, 1, 0, 0);
    tick("t1.b2",  0, 32'h0,        1, 1, 8'hC3, 2, 0, 0);
    tick("t1.b3",  0, 32'h0,        1, 1, 8'hD4, 3, 1, 1);
    tick("t1.end", 0, 32'h0,        1, 0, 8'h00, 0, 0, 1);

    // 2: back-to-back words, second accepted on the last beat of the first
    tick("t2.acc0", 1, 32'h01020304, 1, 0, 8'h00, 0, 0, 1);
    tick("t2.b0",   1, 32'h01020304, 1, 1, 8'h01, 0, 0, 0);
    tick("t2.b1",   1, 32'h01020304, 1, 1, 8'h02, 1, 0, 0);
    tick("t2.b2",   1, 32'h01020304, 1, 1, 8'h03, 2, 0, 0);
    tick("t2.b3",   1, 32'h05060708, 1, 1, 8'h04, 3, 1, 1);
    tick("t2.b4",   1, 32'h05060708, 1, 1, 8'h05, 0, 0, 0);
    tick("t2.b5",   1, 32'h05060708, 1, 1, 8'h06, 1, 0, 0);
    tick("t2.b6",   1, 32'h05060708, 1, 1, 8'h07, 2, 0, 0);
    tick("t2.b7",   0, 32'h0,        1, 1, 8'h08, 3, 1, 1);
    tick("t2.end",  0, 32'h0,        1, 0, 8'h00, 0, 0, 1);

    // 3: backpressure pattern 1,0,0,1,1,0,1
    tick("t3.acc", 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1);
    tick("t3.c1",  0, 32'h0,        1, 1, 8'hA1, 0, 0, 0);
    tick("t3.c2",  0, 32'h0,        0, 1, 8'hB2, 1, 0, 0);
    tick("t3.c3",  1, 32'h99999999, 0, 1, 8'hB2, 1, 0, 0);
    tick("t3.c4",  0, 32'h0,        1, 1, 8'hB2, 1, 0, 0);
    tick("t3.c5",  0, 32'h0,        1, 1, 8'hC3, 2, 0, 0);
    tick("t3.c6",  0, 32'h0,        0, 1, 8'hD4, 3, 1, 0);
    tick("t3.c7",  0, 32'h0,        1, 1, 8'hD4, 3, 1, 1);
    tick("t3.end", 0, 32'h0,        1, 0, 8'h00, 0, 0, 1);

    // 4: stall on the last beat while upstream offers a word
    tick("t4.acc",  1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1);
    tick("t4.b0",   0, 32'h0,        1, 1, 8'hA1, 0, 0, 0);
    tick("t4.b1",   0, 32'h0,        1, 1, 8'hB2, 1, 0, 0);
    tick("t4.b2",   0, 32'h0,        1, 1, 8'hC3, 2, 0, 0);
    tick("t4.st0",  1, 32'h11223344, 0, 1, 8'hD4, 3, 1, 0);
    tick("t4.st1",  1, 32'h11223344, 0, 1, 8'hD4, 3, 1, 0);
    tick("t4.go",   1, 32'h11223344, 1, 1, 8'hD4, 3, 1, 1);
    tick("t4.n0",   0, 32'h0,        1, 1, 8'h11, 0, 0, 0);
    tick("t4.n1",   0, 32'h0,        1, 1, 8'h22, 1, 0, 0);
    tick("t4.n2",   0, 32'h0,        1, 1, 8'h33, 2, 0, 0);
    tick("t4.n3",   0, 32'h0,        1, 1, 8'h44, 3, 1, 1);
    tick("t4.end",  0, 32'h0,        1, 0, 8'h00, 0, 0, 1);

    // 5: reset after B2 transfers
    tick("t5.acc", 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1);
    tick("t5.b0",  0, 32'h0,        1, 1, 8'hA1, 0, 0, 0);
    tick("t5.b1",  0, 32'h0,        1, 1, 8'hB2, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5.ready_in_rst", 32'(m_oready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5.valid", 32'(m_ovalid), 0);
    check("t5.last",  32'(m_olast),  0);
    check("t5.data",  32'(m_odata),  0);
    check("t5.beat",  32'(m_obeat),  0);
    check("t5.ready", 32'(m_oready), 1);
    tick("t5.acc2", 1, 32'h55667788, 1, 0, 8'h00, 0, 0, 1);
    tick("t5.n0",   0, 32'h0,        1, 1, 8'h55, 0, 0, 0);
    tick("t5.n1",   0, 32'h0,        1, 1, 8'h66, 1, 0, 0);
    tick("t5.n2",   0, 32'h0,        1, 1, 8'h77, 2, 0, 0);
    tick("t5.n3",   0, 32'h0,        1, 1, 8'h88, 3, 1, 1);
    tick("t5.end",  0, 32'h0,        1, 0, 8'h00, 0, 0, 1);

    // 6a: LSB-first order
    @(negedge clk);
    l_ivalid = 1; l_idata = 32'hA1B2C3D4; l_iready = 1;
    #1;
    check("t6l.ready", 32'(l_oready), 1);
    @(negedge clk);
    l_ivalid = 0;
    #1;
    check("t6l.d0", 32'(l_odata), 32'hD4);
    check("t6l.k0", 32'(l_obeat), 0);
    check("t6l.l0", 32'(l_olast), 0);
    @(negedge clk); #1;
    check("t6l.d1", 32'(l_odata), 32'hC3);
    check("t6l.k1", 32'(l_obeat), 1);
    @(negedge clk); #1;
    check("t6l.d2", 32'(l_odata), 32'hB2);
    check("t6l.l2", 32'(l_olast), 0);
    @(negedge clk); #1;
    check("t6l.d3", 32'(l_odata), 32'hA1);
    check("t6l.k3", 32'(l_obeat), 3);
    check("t6l.l3", 32'(l_olast), 1);
    @(negedge clk); #1;
    check("t6l.end", 32'(l_ovalid), 0);

    // 6b: NBEATS=1, one word per cycle
    @(negedge clk);
    n_ivalid = 1; n_idata = 8'h5A; n_iready = 1;
    #1;
    check("t6n.ready0", 32'(n_oready), 1);
    @(negedge clk);
    n_idata = 8'h3C;
    #1;
    check("t6n.d0",     32'(n_odata),  32'h5A);
    check("t6n.v0",     32'(n_ovalid), 1);
    check("t6n.l0",     32'(n_olast),  1);
    check("t6n.k0",     32'(n_obeat),  0);
    check("t6n.ready1", 32'(n_oready), 1);
    @(negedge clk);
    n_idata = 8'h7E;
    #1;
    check("t6n.d1", 32'(n_odata), 32'h3C);
    check("t6n.l1", 32'(n_olast), 1);
    @(negedge clk);
    n_ivalid = 0;
    #1;
    check("t6n.d2", 32'(n_odata),  32'h7E);
    check("t6n.v2", 32'(n_ovalid), 1);
    @(negedge clk); #1;
    check("t6n.end", 32'(n_ovalid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
